// File: rtl/pass_check_if.sv
// pass_check_if: keypad strobes in, verdict pulses and entry status out
interface pass_check_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_enter;
  logic       key_clear;
  logic       set_mode;
  logic       right;
  logic       error;
  logic       pass_set;
  logic [3:0] digit_cnt;
  logic       auth;
  modport master (output key_valid, key_code, key_enter, key_clear, set_mode,
                  input right, error, pass_set, digit_cnt, auth);
  modport slave  (input key_valid, key_code, key_enter, key_clear, set_mode,
                  output right, error, pass_set, digit_cnt, auth);
endinterface

// File: rtl/pass_check.sv
// pass_check: collects keypad digits, checks or reprograms a stored password on enter
module pass_check #(
  parameter int          DIGITS       = 4,
  parameter logic [31:0] DEFAULT_PASS = 32'h1234,
  parameter int          TIMEOUT_CYC  = 1000
) (
  input logic   clk,
  input logic   rst,
  pass_check_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, ENTRY, RESULT} state_t;
  state_t state, state_nxt;
  logic [W-1:0]  buffer, stored;
  logic [W+3:0]  shifted;
  logic [3:0]    cnt;
  logic [TW-1:0] tmr;
  logic right, error, pass_set, auth;
  logic in_res, clr, ent, dig, tout, full, match;
  assign shifted = {buffer, bus.key_code};
  always_comb begin
    in_res    = state == RESULT;
    clr       = bus.key_clear && !in_res;
    ent       = bus.key_enter && !bus.key_clear && !in_res;
    dig       = bus.key_valid && !bus.key_clear && !bus.key_enter && !in_res
                && bus.key_code < 4'd10 && cnt < 4'(DIGITS);
    tout      = state == ENTRY && !clr && !ent && !dig && tmr == TW'(TIMEOUT_CYC - 1);
    full      = cnt == 4'(DIGITS);
    match     = full && buffer == stored;
    state_nxt = ent ? RESULT : (in_res || clr || tout) ? IDLE : dig ? ENTRY : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      buffer   <= '0;
      cnt      <= '0;
      stored   <= DEFAULT_PASS[W-1:0];
      tmr      <= '0;
      right    <= 1'b0;
      error    <= 1'b0;
      pass_set <= 1'b0;
      auth     <= 1'b0;
    end else begin
      state    <= state_nxt;
      right    <= 1'b0;
      error    <= 1'b0;
      pass_set <= 1'b0;
      tmr      <= (state_nxt != ENTRY || dig) ? '0 : tmr + 1'b1;
      if (in_res || clr || tout) begin
        buffer <= '0;
        cnt    <= '0;
      end else if (dig) begin
        buffer <= shifted[W-1:0];
        cnt    <= cnt + 4'd1;
      end
      if (clr || tout) auth <= 1'b0;
      // Buffer still holds the entry at this edge; it is cleared when leaving RESULT
      if (ent && bus.set_mode) begin
        auth <= 1'b0;
        if (auth && full) begin
          stored   <= buffer;
          pass_set <= 1'b1;
        end else error <= 1'b1;
      end else if (ent) begin
        right <= match;
        error <= !match;
        auth  <= match;
      end
    end
  end
  assign bus.right     = right;
  assign bus.error     = error;
  assign bus.pass_set  = pass_set;
  assign bus.digit_cnt = cnt;
  assign bus.auth      = auth;
endmodule

// File: tb/tb_pass_check.sv
// tb_pass_check: directed keypad sequences with hand-computed verdicts
module tb_pass_check;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  pass_check_if bus ();
  pass_check #(.DIGITS(4), .DEFAULT_PASS(32'h1234), .TIMEOUT_CYC(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic outs(input string tag, input logic r, input logic e, input logic p, input logic [3:0] c, input logic a);
    chk({tag, ".right"}, 32'(bus.right), 32'(r));
    chk({tag, ".error"}, 32'(bus.error), 32'(e));
    chk({tag, ".pass_set"}, 32'(bus.pass_set), 32'(p));
    chk({tag, ".cnt"}, 32'(bus.digit_cnt), 32'(c));
    chk({tag, ".auth"}, 32'(bus.auth), 32'(a));
  endtask
  task automatic key(input logic [3:0] c);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
  endtask
  task automatic keys(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) key(v[4*i +: 4]);
  endtask
  task automatic enter(input logic clr);
    @(negedge clk);
    bus.key_enter = 1'b1;
    bus.key_clear = clr;
    @(negedge clk);
    bus.key_enter = 1'b0;
    bus.key_clear = 1'b0;
  endtask
  task automatic clear();
    @(negedge clk);
    bus.key_clear = 1'b1;
    @(negedge clk);
    bus.key_clear = 1'b0;
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    #3 rst = 1'b0;
  endtask
  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    bus.key_enter = 1'b0;
    bus.key_clear = 1'b0;
    bus.set_mode  = 1'b0;
    #12;
    outs("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    keys(16'h1234, 4);
    outs("t1.entered", 0, 0, 0, 4, 0);
    enter(0);
    outs("t1.result", 1, 0, 0, 4, 1);
    @(negedge clk);
    outs("t1.after", 0, 0, 0, 0, 1);
    keys(16'h1235, 4);
    enter(0);
    outs("t2.wrong", 0, 1, 0, 4, 0);
    @(negedge clk);
    outs("t2.after", 0, 0, 0, 0, 0);
    keys(16'h0012, 2);
    enter(0);
    outs("t2.short", 0, 1, 0, 2, 0);
    enter(0);
    outs("t2.idle_enter", 0, 1, 0, 0, 0);
    keys(16'h1234, 4);
    key(4'd9);
    chk("t3.cnt_full", 32'(bus.digit_cnt), 32'd4);
    key(4'd12);
    chk("t3.cnt_badcode", 32'(bus.digit_cnt), 32'd4);
    enter(0);
    outs("t3.result", 1, 0, 0, 4, 1);
    bus.set_mode = 1'b1;
    keys(16'h5678, 4);
    enter(0);
    outs("t4.set", 0, 0, 1, 4, 0);
    bus.set_mode = 1'b0;
    keys(16'h1234, 4);
    enter(0);
    outs("t4.old", 0, 1, 0, 4, 0);
    keys(16'h5678, 4);
    enter(0);
    outs("t4.new", 1, 0, 0, 4, 1);
    clear();
    chk("t5.clear_auth", 32'(bus.auth), 32'd0);
    @(negedge clk);
    pulse_rst();
    bus.set_mode = 1'b1;
    keys(16'h5678, 4);
    enter(0);
    outs("t5.unauth_set", 0, 1, 0, 4, 0);
    bus.set_mode = 1'b0;
    keys(16'h1234, 4);
    enter(0);
    outs("t5.default_kept", 1, 0, 0, 4, 1);
    keys(16'h0012, 2);
    enter(1);
    outs("t5.clr_enter", 0, 0, 0, 0, 0);
    @(negedge clk);
    outs("t5.clr_enter2", 0, 0, 0, 0, 0);
    keys(16'h0012, 2);
    repeat (TO - 1) @(negedge clk);
    chk("t6.before_to", 32'(bus.digit_cnt), 32'd2);
    @(negedge clk);
    outs("t6.timeout", 0, 0, 0, 0, 0);
    key(4'd7);
    chk("t6.idle_after_to", 32'(bus.digit_cnt), 32'd1);
    clear();
    keys(16'h0123, 3);
    #2 rst = 1'b1;
    #1 outs("t6.rst_mid", 0, 0, 0, 0, 0);
    rst = 1'b0;
    keys(16'h1234, 4);
    enter(0);
    chk("t6.pre_rst_right", 32'(bus.right), 32'd1);
    #1 rst = 1'b1;
    #1 outs("t6.rst_result", 0, 0, 0, 0, 0);
    rst = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
